// File: rtl/fma16_seq.sv
// Sequencer that arbitrates two requesters onto a single fma16 datapath.
// It runs one operation at a time and returns the result and flags through a valid/ready response port.
module fma16_seq #(
    parameter int CORE_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  rq_valid,
    output logic [1:0]  rq_ready,
    input  logic [31:0] rq_x,
    input  logic [31:0] rq_y,
    input  logic [31:0] rq_z,
    input  logic [1:0]  rq_negp,
    input  logic [1:0]  rq_negz,
    output logic [15:0] core_x,
    output logic [15:0] core_y,
    output logic [15:0] core_z,
    output logic        core_negp,
    output logic        core_negz,
    input  logic [15:0] core_result,
    input  logic [3:0]  core_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic [3:0]  acc_flags,
    input  logic        flags_clr
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    localparam logic [3:0] LAT_LOAD = 4'(CORE_LAT - 1);

    state_e      state;
    state_e      stateNext;
    logic        prio;
    logic [3:0]  cnt;
    logic        grantLane;
    logic        grantAny;
    logic        accept;
    logic        rspXfer;
    logic [15:0] opX;
    logic [15:0] opY;
    logic [15:0] opZ;
    logic        opNegP;
    logic        opNegZ;

    // Round-robin choice: a lone requester always wins, and prio breaks ties.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        grantLane = prio;
        grantAny  = |rq_valid;
        if (rq_valid == 2'b01)
            grantLane = 1'b0;
        else if (rq_valid == 2'b10)
            grantLane = 1'b1;
    end

    assign accept  = (state == IDLE) && grantAny;
    assign rspXfer = (state == RESP) && rsp_ready;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = EXEC;
            EXEC:    if (cnt == 4'd0) stateNext = RESP;
            RESP:    if (rsp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        rq_ready  = 2'b00;
        rsp_valid = 1'b0;
        case (state)
            IDLE: if (grantAny) rq_ready[grantLane] = 1'b1;
            RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture and cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio   <= 1'b0;
            cnt    <= 4'd0;
            opX    <= 16'h0000;
            opY    <= 16'h0000;
            opZ    <= 16'h0000;
            opNegP <= 1'b0;
            opNegZ <= 1'b0;
            rsp_id <= 1'b0;
        end else if (accept) begin
            prio   <= ~grantLane;
            cnt    <= LAT_LOAD;
            opX    <= grantLane ? rq_x[31:16] : rq_x[15:0];
            opY    <= grantLane ? rq_y[31:16] : rq_y[15:0];
            opZ    <= grantLane ? rq_z[31:16] : rq_z[15:0];
            opNegP <= rq_negp[grantLane];
            opNegZ <= rq_negz[grantLane];
            rsp_id <= grantLane;
        end else if (state == EXEC && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Result capture at the end of EXEC and sticky flag accumulation on delivery.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_result <= 16'h0000;
            rsp_flags  <= 4'h0;
            acc_flags  <= 4'h0;
        end else begin
            if (state == EXEC && cnt == 4'd0) begin
                rsp_result <= core_result;
                rsp_flags  <= core_flags;
            end
            // Clear takes effect first, so a coincident delivery leaves only its own flags.
            if (flags_clr)
                acc_flags <= rspXfer ? rsp_flags : 4'h0;
            else if (rspXfer)
                acc_flags <= acc_flags | rsp_flags;
        end
    end

    assign core_x    = opX;
    assign core_y    = opY;
    assign core_z    = opZ;
    assign core_negp = opNegP;
    assign core_negz = opNegZ;

endmodule

// File: doc/fma16_seq.md
FMA16_SEQ -- requirements
Module: fma16_seq

Interface
REQ-001 Parameter CORE_LAT, default 1, gives the cycles from operands held on core_* to core_result/core_flags valid; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rq_valid  input  2  per-requester operation valid; bit i belongs to requester i.
REQ-005 rq_ready  output  2  per-requester accept; a transfer on lane i is rq_valid[i] & rq_ready[i].
REQ-006 rq_x, rq_y, rq_z  input  32 each  half-precision operands; lane i occupies bits [16i+15:16i].
REQ-007 rq_negp, rq_negz  input  2 each  per-lane negate-product / negate-addend controls.
REQ-008 core_x, core_y, core_z  output  16 each  operands driven to the fma16 datapath.
REQ-009 core_negp, core_negz  output  1 each  negate controls driven to the datapath.
REQ-010 core_result  input  16  datapath result.
REQ-011 core_flags  input  4  datapath flags {NV, OF, UF, NX}.
REQ-012 rsp_valid  output  1  response valid.
REQ-013 rsp_ready  input  1  response accept; transfer is rsp_valid & rsp_ready.
REQ-014 rsp_id  output  1  requester index of the response.
REQ-015 rsp_result, rsp_flags  output  16, 4  captured result and flags.
REQ-016 acc_flags  output  4  sticky OR of every delivered rsp_flags.
REQ-017 flags_clr  input  1  synchronous clear of acc_flags.

Function
REQ-018 FSM states: IDLE, EXEC, RESP; only one operation in flight.
REQ-019 IDLE: rq_ready = grant vector (one-hot or zero); all other states rq_ready = 2'b00.
REQ-020 Arbitration round-robin: pointer prio (1 bit) names the preferred lane; if both valid, grant lane prio; if one valid, grant it.
REQ-021 On an accepted transfer, prio becomes the non-granted lane; prio unchanged when no transfer.
REQ-022 On transfer, operands, neg controls and lane index are registered; core_* driven from these registers only, held stable through EXEC.
REQ-023 IDLE -> EXEC on transfer; cycle counter loaded with CORE_LAT-1.
REQ-024 EXEC: counter decrements each cycle; at count 0, core_result and core_flags are captured into rsp_result/rsp_flags and state -> RESP; exactly CORE_LAT cycles in EXEC.
REQ-025 RESP: rsp_valid = 1; rsp_result, rsp_flags, rsp_id stable until transfer; RESP -> IDLE on rsp_ready.
REQ-026 Latency: accept edge to rsp_valid high = CORE_LAT+1 cycles with CORE_LAT=1 -> rsp_valid asserts 2 cycles after acceptance.
REQ-027 Throughput: back-to-back ops; new acceptance no earlier than the cycle after rsp transfer (IDLE cycle mandatory).
REQ-028 acc_flags |= rsp_flags on each rsp transfer.
REQ-029 flags_clr with simultaneous rsp transfer: acc_flags = rsp_flags (clear then accumulate same cycle); flags_clr alone: acc_flags = 0.
REQ-030 core_* outputs irrelevant in IDLE but hold last registered operands (no X).
REQ-031 rq_valid deassert without handshake: no state change; requester may drop valid freely.

Reset
REQ-032 reset: state = IDLE, prio = 0, counter = 0, rsp_valid = 0, rsp_id = 0, rsp_result = 16'h0000, rsp_flags = 4'h0, acc_flags = 4'h0, operand registers = 0.
REQ-033 reset in EXEC or RESP aborts the operation; no response delivered, acc_flags not updated.
REQ-034 reset dominates flags_clr, rsp_ready and rq_valid in the same cycle.

Verification
REQ-035 Single op lane0 x=3C00, y=4000, z=3C00, core model returns 4200/0 -> rsp_valid 2 cycles later, rsp_id=0, rsp_result=4200, rsp_flags=0.
REQ-036 Both lanes valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 starting lane 0 after reset.
REQ-037 Core flags 4'b1000 then 4'b0001 on two ops -> acc_flags 1000 then 1001; flags_clr pulse -> 0000.
REQ-038 rsp_ready held 0 for 5 cycles in RESP -> rsp_* stable, rq_ready=00 throughout; release -> IDLE next cycle.
REQ-039 CORE_LAT=3, reset asserted in second EXEC cycle -> all outputs at reset values next cycle, no rsp_valid.
REQ-040 flags_clr coincident with rsp transfer carrying 0100 while acc_flags=0001 -> acc_flags=0100.
